// File: rtl/reg_file_swap.sv
// Two-read / one-write register file with a built-in swap engine that exchanges
// two registers over a fixed LOAD / WR_A / WR_B / DONE sequence.
module reg_file_swap #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE,
    input  logic              swap_start,
    input  logic [ADDR_W-1:0] swap_a,
    input  logic [ADDR_W-1:0] swap_b,
    output logic              swap_busy,
    output logic              swap_done,
    output logic              wr_blocked
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [DATA_W-1:0]   tmp_reg;
    logic [ADDR_W-1:0]   swap_a_reg;
    logic [ADDR_W-1:0]   swap_b_reg;

    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    reg_we;

    logic                wr_en;
    logic                wr_commit;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    logic [ADDR_W-1:0]   rd_addr [2];
    logic [DATA_W-1:0]   rd_data [2];
    logic                ext_wr_live;

    // The array has a single write port shared by the datapath (IDLE only)
    // and the two swap write phases.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = A3;
        wr_data = WD3;
        case (state_reg)
            S_IDLE: wr_en = WE;
            S_WR_A: begin
                wr_en   = 1'b1;
                wr_addr = swap_a_reg;
                wr_data = regs[swap_b_reg];
            end
            S_WR_B: begin
                wr_en   = 1'b1;
                wr_addr = swap_b_reg;
                wr_data = tmp_reg;
            end
            default: wr_en = 1'b0;
        endcase
    end

    assign wr_commit = wr_en && !(ZERO_REG && (wr_addr == '0));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign reg_we[gi] = wr_commit && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reg_we[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Forwarding only applies to external writes that will actually commit.
    assign ext_wr_live = BYPASS && WE && (state_reg == S_IDLE)
                         && !(ZERO_REG && (A3 == '0));

    assign rd_addr[0] = A1;
    assign rd_addr[1] = A2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = regs[rd_addr[gi]];
                if (ZERO_REG && (rd_addr[gi] == '0)) begin
                    rd_data[gi] = '0;
                end else if (ext_wr_live && (A3 == rd_addr[gi])) begin
                    rd_data[gi] = WD3;
                end
            end
        end
    endgenerate

    assign RD1 = rd_data[0];
    assign RD2 = rd_data[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            tmp_reg    <= '0;
            swap_a_reg <= '0;
            swap_b_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_IDLE) && swap_start) begin
                swap_a_reg <= swap_a;
                swap_b_reg <= swap_b;
            end
            if (state_reg == S_LOAD) begin
                tmp_reg <= regs[swap_a_reg];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (swap_start) state_next = S_LOAD;
            S_LOAD:  state_next = S_WR_A;
            S_WR_A:  state_next = S_WR_B;
            S_WR_B:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        swap_busy  = (state_reg != S_IDLE);
        swap_done  = (state_reg == S_DONE);
        wr_blocked = WE && (state_reg != S_IDLE);
    end

endmodule
